ace_fetch_pcgen: RTL
====================

Name: ace_fetch_pcgen

Overview:
Next-fetch-PC controller that sequences the two-stage fetch pipeline (f0 BTB/icache lookup, f1 branch decode/BPD).
- Owns the f0/f1 PC registers and their valid bits.
- Each cycle, arbitrates the next f0 PC among the reset vector, retire flush, f1 override, and the f0 predicted PC.
- Freezes the pipeline on icache, instruction-buffer or BOB back-pressure.
- Sits between retire/fetch-f1 redirect sources and the icache/BTB/BPD index inputs.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, fetch address after reset; bits [1:0] must be 0.
FETCH_BYTES, 32, bytes per fetch block (8 x 32-bit instructions); informational, not used in arithmetic.

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
flush_rt_i  in  1  retire-stage flush request
flush_pc_rt_i  in  64  flush target PC
override_vld_f1_i  in  1  f1 redirect (decode/BPD disagrees with f0 prediction)
override_pc_f1_i  in  64  f1 redirect target
nxt_pc_f0_i  in  64  f0 predicted next PC (BTB/RAS/sequential)
icache_stall_i  in  1  icache miss/busy
instbuf_full_i  in  1  instruction buffer full
bob_stall_i  in  1  branch-order buffer full
pc_f0_o  out  64  PC in fetch stage 0
pc_f1_o  out  64  PC in fetch stage 1
pc_vld_f0_o  out  1  f0 holds a live fetch
pc_vld_f1_o  out  1  f1 holds a live fetch
icache_req_o  out  1  issue icache lookup at pc_f0_o
kill_f0_o  out  1  combinational: squash current f0 contents
state_o  out  2  FSM state (IDLE=00, RUN=01, STALL=10, FLUSH=11)
stall_cnt_o  out  32  saturating count of hold cycles
redirect_cnt_o  out  16  saturating count of accepted f1 overrides

Behaviour:
- Reset (async, reset_n low), all outputs/registers:
  - pc_f0_o=RESET_PC, pc_f1_o=0.
  - pc_vld_f0_o=0, pc_vld_f1_o=0.
  - state=IDLE, stall_cnt_o=0, redirect_cnt_o=0.
  - icache_req_o=0, kill_f0_o=0.
  - Reset asserted mid-operation discards all state immediately.
- hold = icache_stall_i | instbuf_full_i | bob_stall_i.
- ovr = override_vld_f1_i & pc_vld_f1_o; ignored when f1 is invalid.
- Redirect PCs are loaded with bits [1:0] forced to 0.
- Decision each clock edge, in priority order:
  - P1 flush_rt_i (any state, including IDLE and during hold):
    - pc_f0<=flush_pc_rt_i; pc_vld_f0<=1; pc_vld_f1<=0; state<=FLUSH.
  - P2 state==IDLE:
    - pc_vld_f0<=1; state<=RUN; pc_f0 keeps RESET_PC.
  - P3 state==FLUSH:
    - one bubble cycle, no icache request; state<=RUN; PCs hold.
  - P4 hold (RUN/STALL):
    - all PC/valid registers hold; state<=STALL.
    - stall_cnt_o+=1, saturating at 32'hFFFF_FFFF.
    - A pending ovr is not consumed; it is re-evaluated when hold drops, because f1 is frozen.
  - P5 ovr:
    - pc_f0<=override_pc_f1_i; pc_vld_f0<=1; pc_vld_f1<=0 (wrong-path f0 squashed).
    - redirect_cnt_o+=1, saturating at 16'hFFFF; state<=RUN.
  - P6 otherwise (advance):
    - pc_f1<=pc_f0; pc_vld_f1<=pc_vld_f0; pc_f0<=nxt_pc_f0_i; pc_vld_f0<=1; state<=RUN.
- icache_req_o = pc_vld_f0_o & (state==RUN | state==STALL) & ~flush_rt_i.
- kill_f0_o = flush_rt_i | (ovr & ~hold).
- Latency:
  - flush to first icache request = 2 cycles (FLUSH bubble).
  - override to new f0 PC = 1 cycle.
  - reset release to first request = 2 cycles.
- Simultaneous events:
  - flush + override: flush wins; override dropped, not counted.
  - flush + hold: flush wins; stall_cnt not incremented.
- Wrap-around: nxt_pc_f0_i is taken as-is; no internal PC arithmetic, so 64-bit overflow is the producer's concern.
- Counters never wrap; they clear only on reset.

Test Plan:
1. Reset with RESET_PC=64'h1000, release reset, nxt_pc_f0_i=pc_f0+32 -> cycle1 state=IDLE, req=0; cycle2 RUN, pc_f0=0x1000, req=1; cycle3 pc_f0=0x1020, pc_f1=0x1000, vld_f1=1.
2. In RUN at pc_f0=0x1040, pulse flush_rt_i with flush_pc_rt_i=0x2003 -> next: pc_f0=0x2000, vld_f1=0, state=FLUSH, req=0; following cycle state=RUN, req=1.
3. vld_f1=1, override_vld_f1_i=1, override_pc_f1_i=0x3000, no hold -> kill_f0_o=1 same cycle; next pc_f0=0x3000, vld_f1=0, redirect_cnt_o=1.
4. icache_stall_i high 5 cycles with override pending -> PCs frozen, state=STALL, stall_cnt_o=5, redirect_cnt_o unchanged; cycle after stall drops, override taken, pc_f0=override PC.
5. flush_rt_i, override_vld_f1_i and instbuf_full_i all high together -> pc_f0=flush PC, state=FLUSH, redirect_cnt_o and stall_cnt_o unchanged.
6. Force stall_cnt_o to 32'hFFFF_FFFF via long hold; further hold -> stays saturated. Assert reset_n low mid-STALL -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ace_fetch_pcgen.sv
// ace_fetch_pcgen: next-fetch-PC controller for the two-stage (f0/f1) fetch pipeline.
// Ports:
//   clock, reset_n                     core clock, asynchronous active-low reset
//   flush_rt_i / flush_pc_rt_i         retire flush request and target
//   override_vld_f1_i / override_pc_f1_i  f1 redirect request and target
//   nxt_pc_f0_i                        f0 predicted next PC
//   icache_stall_i, instbuf_full_i, bob_stall_i  back-pressure sources
//   pc_f0_o, pc_f1_o, pc_vld_f0_o, pc_vld_f1_o   stage PCs and valids
//   icache_req_o, kill_f0_o            icache lookup request, f0 squash
//   state_o, stall_cnt_o, redirect_cnt_o  FSM state and saturating counters
module ace_fetch_pcgen #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          FETCH_BYTES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush_rt_i,
    input  logic [63:0] flush_pc_rt_i,
    input  logic        override_vld_f1_i,
    input  logic [63:0] override_pc_f1_i,
    input  logic [63:0] nxt_pc_f0_i,
    input  logic        icache_stall_i,
    input  logic        instbuf_full_i,
    input  logic        bob_stall_i,
    output logic [63:0] pc_f0_o,
    output logic [63:0] pc_f1_o,
    output logic        pc_vld_f0_o,
    output logic        pc_vld_f1_o,
    output logic        icache_req_o,
    output logic        kill_f0_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] redirect_cnt_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STALL = 2'b10, FLUSH = 2'b11} state_t;

    if (RESET_PC[1:0] != 2'b00 || FETCH_BYTES != 32) begin : g_bad_param
        $error("ace_fetch_pcgen: RESET_PC must be 4-byte aligned and FETCH_BYTES must be 32");
    end

    state_t      st, nst;
    logic [63:0] pc_f0, pc_f1, npc_f0, npc_f1;
    logic        vld_f0, vld_f1, nvld_f0, nvld_f1;
    logic [31:0] stall_cnt, nstall_cnt;
    logic [15:0] redirect_cnt, nredirect_cnt;
    logic        hold, ovr;

    assign hold = icache_stall_i | instbuf_full_i | bob_stall_i;
    // An override from an empty f1 slot is stale and must not redirect.
    assign ovr  = override_vld_f1_i & vld_f1;

    always_comb begin
        nst           = st;
        npc_f0        = pc_f0;
        npc_f1        = pc_f1;
        nvld_f0       = vld_f0;
        nvld_f1       = vld_f1;
        nstall_cnt    = stall_cnt;
        nredirect_cnt = redirect_cnt;
        if (flush_rt_i) begin
            npc_f0  = {flush_pc_rt_i[63:2], 2'b00};
            nvld_f0 = 1'b1;
            nvld_f1 = 1'b0;
            nst     = FLUSH;
        end else if (st == IDLE) begin
            nvld_f0 = 1'b1;
            nst     = RUN;
        end else if (st == FLUSH) begin
            nst = RUN;
        end else if (hold) begin
            // f1 is frozen too, so a pending override survives until hold drops.
            nst        = STALL;
            nstall_cnt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 32'd1;
        end else if (ovr) begin
            npc_f0        = {override_pc_f1_i[63:2], 2'b00};
            nvld_f0       = 1'b1;
            nvld_f1       = 1'b0;
            nredirect_cnt = (redirect_cnt == '1) ? redirect_cnt : redirect_cnt + 16'd1;
            nst           = RUN;
        end else begin
            npc_f1  = pc_f0;
            nvld_f1 = vld_f0;
            npc_f0  = nxt_pc_f0_i;
            nvld_f0 = 1'b1;
            nst     = RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st           <= IDLE;
            pc_f0        <= RESET_PC;
            pc_f1        <= '0;
            vld_f0       <= 1'b0;
            vld_f1       <= 1'b0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            st           <= nst;
            pc_f0        <= npc_f0;
            pc_f1        <= npc_f1;
            vld_f0       <= nvld_f0;
            vld_f1       <= nvld_f1;
            stall_cnt    <= nstall_cnt;
            redirect_cnt <= nredirect_cnt;
        end
    end

    assign pc_f0_o        = pc_f0;
    assign pc_f1_o        = pc_f1;
    assign pc_vld_f0_o    = vld_f0;
    assign pc_vld_f1_o    = vld_f1;
    assign state_o        = st;
    assign stall_cnt_o    = stall_cnt;
    assign redirect_cnt_o = redirect_cnt;
    assign icache_req_o   = vld_f0 & (st == RUN | st == STALL) & ~flush_rt_i;
    // Gated by reset_n so the squash stays low while the block is held in reset.
    assign kill_f0_o      = reset_n & (flush_rt_i | (ovr & ~hold));
endmodule
